// File: rtl/mod997_reduce_serial.sv
// Digit-serial reducer: value mod MOD, MSB-first, one DIG_W-bit digit per clock.
// Each step folds acc*2^DIG_W + digit back into [0,MOD-1] by parallel compares.
module mod997_reduce_serial #(
    parameter int unsigned MOD   = 997,
    parameter int unsigned IN_W  = 20,
    parameter int unsigned DIG_W = 3,
    parameter int unsigned OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    localparam int unsigned NDIG  = (IN_W + DIG_W - 1) / DIG_W;
    localparam int unsigned PAD_W = NDIG * DIG_W;
    localparam int unsigned T_W   = OUT_W + DIG_W;
    localparam int unsigned CNT_W = $clog2(NDIG + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAD_W-1:0] shreg_q, shreg_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic [DIG_W-1:0] digit;
    logic [T_W-1:0]   t;
    logic [OUT_W-1:0] acc_red;

    // t = acc*2^DIG_W + digit; subtract the largest k*MOD not exceeding t.
    always_comb begin
        digit   = shreg_q[PAD_W-1 -: DIG_W];
        t       = {acc_q, digit};
        acc_red = t[OUT_W-1:0];
        for (int unsigned k = 1; k < (1 << DIG_W); k++) begin
            if (t >= T_W'(k * MOD)) begin
                acc_red = OUT_W'(t - T_W'(k * MOD));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_d = PAD_W'(in_data);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = acc_red;
                shreg_d = shreg_q << DIG_W;
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_red;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod997_reduce_serial.sv
// Self-checking bench for mod997_reduce_serial: directed cases then random traffic
// against a plain-arithmetic x % 997 model with an in-order expectation queue.
module tb_mod997_reduce_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mod997_reduce_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present v and hold in_valid until the edge that accepts it.
    task automatic send(input logic [19:0] v);
        int w = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_wait", 32'(w < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 20'($urandom);
    endtask

    // Wait for out_valid, check latency and value, then consume the result.
    task automatic recv(input string tag, input int exp, input bit chk_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int    exp_q[$];
        int    sent;
        int    got;
        int    cyc;
        bit    ov_seen;
        int    v;
        bit    in_hs;
        bit    out_hs;
        int    exp_v;
        localparam int NRAND = 3000;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed values, including the all-ones input that exercises padding.
        send(20'd0);       recv("zero", 0, 1'b1);
        send(20'd997);     recv("mod", 0, 1'b1);
        send(20'd994008);  recv("v994008", 996, 1'b1);
        send(20'hFFFFF);   recv("max", 728, 1'b1);

        // Backpressure: result held, no new input accepted.
        send(20'd123456);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd7);
        in_valid = 1'b1;
        in_data  = 20'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 32'(out_data), 32'd825);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_no_passthru", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset while digits are still being consumed.
        send(20'd555555);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_output", 32'(ov_seen), 32'd0);
        check("midrst_idle", 32'(in_ready), 32'd1);
        send(20'd997);     recv("after_rst", 0, 1'b1);

        // Random traffic with random in_valid/out_ready; results must come in order.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < NRAND && cyc < 90000) begin
            if (sent < NRAND) begin
                in_valid = ($urandom_range(0, 1) == 1);
                case ($urandom_range(0, 9))
                    0:       in_data = 20'hFFFFF;
                    1:       in_data = 20'(997 * $urandom_range(0, 1051));
                    default: in_data = 20'($urandom);
                endcase
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("rand_data", 32'(out_data), 32'(exp_v));
                got++;
            end
            if (in_hs) begin
                v = int'(in_data);
                exp_q.push_back(v % 997);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_all_received", 32'(got), 32'(NRAND));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check("rand_no_extra", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
